// File: rtl/lab9_soc_dualport_ram_if.sv
// Avalon-MM slave port bundle for one side of the lab9 dual-port RAM.
// The master modport drives requests; the slave modport answers them.
interface lab9_soc_dualport_ram_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/lab9_soc_dualport_ram.sv
// Dual-port on-chip RAM for the lab9 SoC: two Avalon-MM slaves, write-first
// reads with cross-port forwarding, and alternating priority on write collisions.
module lab9_soc_dualport_ram #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter              INIT_FILE    = "lab9_soc_dualport_ram.hex"
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clken,
  lab9_soc_dualport_ram_if.slave s1,
  lab9_soc_dualport_ram_if.slave s2
);
  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_e;

  word_t mem_q [DEPTH];

  // Index 0 is port A (s1), index 1 is port B (s2).
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [NBYTES-1:0]     be    [2];
  word_t                 wdata [2];
  logic [1:0]            cs, rd, wr;

  assign addr[0]  = s1.address;
  assign addr[1]  = s2.address;
  assign be[0]    = s1.byteenable;
  assign be[1]    = s2.byteenable;
  assign wdata[0] = s1.writedata;
  assign wdata[1] = s2.writedata;
  assign cs       = {s2.chipselect, s1.chipselect};
  assign rd       = {s2.read, s1.read};
  assign wr       = {s2.write, s1.write};

  prio_e      prio_q, prio_d;
  logic       collision;
  logic [1:0] wait_w, wr_acc, rd_acc, in_range, mem_we;
  word_t      rd_word [2];

  always_comb begin
    collision = cs[0] & wr[0] & cs[1] & wr[1] & (addr[0] == addr[1]);
    wait_w[0] = ~clken | (collision & (prio_q == PRIO_B));
    wait_w[1] = ~clken | (collision & (prio_q == PRIO_A));

    prio_d = prio_q;
    if (clken && collision) begin
      prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
    end

    for (int unsigned p = 0; p < 2; p++) begin
      in_range[p] = (32'(addr[p]) < DEPTH);
      wr_acc[p]   = reset_n & ~wait_w[p] & cs[p] & wr[p];
      rd_acc[p]   = reset_n & ~wait_w[p] & cs[p] & rd[p] & ~wr[p];
      mem_we[p]   = wr_acc[p] & in_range[p];
    end

    // Write-first: overlay this cycle's accepted writes onto the stored word.
    // Both ports can never write the same address in one cycle, so order is irrelevant.
    for (int unsigned p = 0; p < 2; p++) begin
      rd_word[p] = '0;
      if (in_range[p]) begin
        rd_word[p] = mem_q[addr[p][IDX_W-1:0]];
        for (int unsigned q = 0; q < 2; q++) begin
          if (mem_we[q] && (addr[q] == addr[p])) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
              if (be[q][b]) begin
                rd_word[p][8*b +: 8] = wdata[q][8*b +: 8];
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (mem_we[p] && be[p][b]) begin
          mem_q[addr[p][IDX_W-1:0]][8*b +: 8] <= wdata[p][8*b +: 8];
        end
      end
    end
  end

  logic [1:0] rv1_q, rv1_d;
  word_t      rd1_q [2];
  word_t      rd1_d [2];

  always_comb begin
    rv1_d = rv1_q;
    rd1_d = rd1_q;
    if (clken) begin
      rv1_d = rd_acc;
      for (int unsigned p = 0; p < 2; p++) begin
        if (rd_acc[p]) begin
          rd1_d[p] = rd_word[p];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= PRIO_A;
      rv1_q  <= '0;
      rd1_q  <= '{default: '0};
    end else begin
      prio_q <= prio_d;
      rv1_q  <= rv1_d;
      rd1_q  <= rd1_d;
    end
  end

  logic [1:0] rv_out;
  word_t      rd_out [2];

  if (READ_LATENCY == 2) begin : g_lat2
    logic [1:0] rv2_q, rv2_d;
    word_t      rd2_q [2];
    word_t      rd2_d [2];

    always_comb begin
      rv2_d = rv2_q;
      rd2_d = rd2_q;
      if (clken) begin
        rv2_d = rv1_q;
        for (int unsigned p = 0; p < 2; p++) begin
          if (rv1_q[p]) begin
            rd2_d[p] = rd1_q[p];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rv2_q <= '0;
        rd2_q <= '{default: '0};
      end else begin
        rv2_q <= rv2_d;
        rd2_q <= rd2_d;
      end
    end

    assign rv_out = rv2_q;
    assign rd_out = rd2_q;
  end else begin : g_lat1
    assign rv_out = rv1_q;
    assign rd_out = rd1_q;
  end

  assign s1.waitrequest   = wait_w[0];
  assign s2.waitrequest   = wait_w[1];
  assign s1.readdatavalid = rv_out[0];
  assign s2.readdatavalid = rv_out[1];
  assign s1.readdata      = rd_out[0];
  assign s2.readdata      = rd_out[1];
endmodule

// File: tb/tb_lab9_soc_dualport_ram.sv
// Directed bench for lab9_soc_dualport_ram: one latency-1 instance with DEPTH=1000
// and one latency-2 instance with DEPTH=1024.
module tb_lab9_soc_dualport_ram;
  logic clk = 1'b0;
  logic reset_n;
  logic clken0, clken1;
  int   n_vec, n_bad;

  always #5 clk = ~clk;

  lab9_soc_dualport_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) a0 ();
  lab9_soc_dualport_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b0 ();
  lab9_soc_dualport_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) a1 ();
  lab9_soc_dualport_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) b1 ();

  lab9_soc_dualport_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(1), .INIT_FILE("")
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .clken(clken0), .s1(a0), .s2(b0)
  );

  lab9_soc_dualport_ram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1024), .READ_LATENCY(2), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .reset_n(reset_n), .clken(clken1), .s1(a1), .s2(b1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int unsigned i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  task automatic a0_drv(input int c, input int r, input int w, input int unsigned ad,
                        input logic [31:0] d, input logic [3:0] be);
    a0.chipselect = (c != 0); a0.read = (r != 0); a0.write = (w != 0);
    a0.address = 10'(ad); a0.writedata = d; a0.byteenable = be;
  endtask

  task automatic b0_drv(input int c, input int r, input int w, input int unsigned ad,
                        input logic [31:0] d, input logic [3:0] be);
    b0.chipselect = (c != 0); b0.read = (r != 0); b0.write = (w != 0);
    b0.address = 10'(ad); b0.writedata = d; b0.byteenable = be;
  endtask

  task automatic a1_drv(input int c, input int r, input int w, input int unsigned ad,
                        input logic [31:0] d, input logic [3:0] be);
    a1.chipselect = (c != 0); a1.read = (r != 0); a1.write = (w != 0);
    a1.address = 10'(ad); a1.writedata = d; a1.byteenable = be;
  endtask

  task automatic b1_drv(input int c, input int r, input int w, input int unsigned ad,
                        input logic [31:0] d, input logic [3:0] be);
    b1.chipselect = (c != 0); b1.read = (r != 0); b1.write = (w != 0);
    b1.address = 10'(ad); b1.writedata = d; b1.byteenable = be;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned idx;
    int unsigned nrecv;
    logic        held_v;
    logic [31:0] held_d;

    n_vec = 0; n_bad = 0;
    reset_n = 1'b0; clken0 = 1'b1; clken1 = 1'b1;
    a0_drv(0, 0, 0, 0, 32'h0, 4'h0); b0_drv(0, 0, 0, 0, 32'h0, 4'h0);
    a1_drv(0, 0, 0, 0, 32'h0, 4'h0); b1_drv(0, 0, 0, 0, 32'h0, 4'h0);
    repeat (3) tick;
    check_eq("rst_a_rdv",   32'(a0.readdatavalid), 32'd0);
    check_eq("rst_b_rdata", b0.readdata, 32'h0);
    check_eq("rst_a_wait",  32'(a0.waitrequest), 32'd0);
    check_eq("rst_l2_rdv",  32'(b1.readdatavalid), 32'd0);
    reset_n = 1'b1;

    a0_drv(1, 0, 1, 5,   32'hDEAD_BEEF, 4'hF); tick;
    a0_drv(1, 0, 1, 7,   32'h1122_3344, 4'hF); tick;
    a0_drv(1, 0, 1, 999, 32'h1234_5678, 4'hF); tick;
    a0_drv(0, 0, 0, 0, 32'h0, 4'h0);

    b0_drv(1, 1, 0, 5, 32'h0, 4'h0);
    #1 check_eq("b_rd5_wait", 32'(b0.waitrequest), 32'd0);
    tick;
    check_eq("b_rd5_rdv",  32'(b0.readdatavalid), 32'd1);
    check_eq("b_rd5_data", b0.readdata, 32'hDEAD_BEEF);
    b0_drv(0, 0, 0, 0, 32'h0, 4'h0);
    tick;
    check_eq("b_idle_rdv",  32'(b0.readdatavalid), 32'd0);
    check_eq("b_hold_data", b0.readdata, 32'hDEAD_BEEF);

    b0_drv(1, 1, 0, 7, 32'h0, 4'h0);
    tick;
    check_eq("b_rd7_rdv",  32'(b0.readdatavalid), 32'd1);
    check_eq("b_rd7_data", b0.readdata, 32'h1122_3344);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_rdv",   32'(b0.readdatavalid), 32'd0);
    check_eq("async_rst_rdata", b0.readdata, 32'h0);
    b0_drv(0, 0, 0, 0, 32'h0, 4'h0);
    tick;
    reset_n = 1'b1;
    tick;
    check_eq("post_rst_rdv", 32'(b0.readdatavalid), 32'd0);

    a0_drv(1, 0, 1, 7, 32'hAABB_CCDD, 4'b0101);
    b0_drv(1, 1, 0, 7, 32'h0, 4'h0);
    tick;
    check_eq("fwd_rdv",  32'(b0.readdatavalid), 32'd1);
    check_eq("fwd_data", b0.readdata, 32'h11BB_33DD);
    a0_drv(0, 0, 0, 0, 32'h0, 4'h0);
    tick;
    check_eq("be_mem_data", b0.readdata, 32'h11BB_33DD);

    a0_drv(1, 0, 1, 3, 32'h1, 4'hF);
    b0_drv(1, 0, 1, 3, 32'h2, 4'hF);
    #1;
    check_eq("col1_a_wait", 32'(a0.waitrequest), 32'd0);
    check_eq("col1_b_wait", 32'(b0.waitrequest), 32'd1);
    tick; #1;
    check_eq("col2_a_wait", 32'(a0.waitrequest), 32'd1);
    check_eq("col2_b_wait", 32'(b0.waitrequest), 32'd0);
    tick; #1;
    check_eq("col3_a_wait", 32'(a0.waitrequest), 32'd0);
    check_eq("col3_b_wait", 32'(b0.waitrequest), 32'd1);
    tick;
    a0_drv(0, 0, 0, 0, 32'h0, 4'h0);
    b0_drv(1, 1, 0, 3, 32'h0, 4'h0);
    tick;
    check_eq("col_final", b0.readdata, 32'h1);
    b0_drv(0, 0, 0, 0, 32'h0, 4'h0);

    a0_drv(1, 0, 1, 1010, 32'hFFFF_FFFF, 4'hF);
    #1 check_eq("oor_wr_wait", 32'(a0.waitrequest), 32'd0);
    tick;
    a0_drv(1, 1, 0, 1010, 32'h0, 4'h0);
    #1 check_eq("oor_rd_wait", 32'(a0.waitrequest), 32'd0);
    tick;
    check_eq("oor_rdv",  32'(a0.readdatavalid), 32'd1);
    check_eq("oor_data", a0.readdata, 32'h0);
    a0_drv(1, 1, 0, 999, 32'h0, 4'h0);
    tick;
    check_eq("addr999", a0.readdata, 32'h1234_5678);
    a0_drv(0, 0, 0, 0, 32'h0, 4'h0);

    for (int i = 0; i < 16; i++) begin
      a1_drv(1, 0, 1, i, pat(i), 4'hF);
      tick;
    end
    a1_drv(1, 0, 1, 20, 32'h0000_0055, 4'hF);
    tick;
    a1_drv(0, 0, 0, 0, 32'h0, 4'h0);

    for (int k = 0; k < 18; k++) begin
      logic exp_v;
      if (k < 16) b1_drv(1, 1, 0, k, 32'h0, 4'h0);
      else        b1_drv(0, 0, 0, 0, 32'h0, 4'h0);
      tick;
      exp_v = (k >= 1) && (k <= 16);
      check_eq("l2_rdv", 32'(b1.readdatavalid), 32'(exp_v));
      if (exp_v) check_eq("l2_data", b1.readdata, pat(k - 1));
    end

    idx = 0; nrecv = 0;
    held_v = b1.readdatavalid; held_d = b1.readdata;
    for (int c = 0; c < 30; c++) begin
      clken1 = !((c >= 5) && (c < 8));
      if (idx < 16) b1_drv(1, 1, 0, idx, 32'h0, 4'h0);
      else          b1_drv(0, 0, 0, 0, 32'h0, 4'h0);
      if (!clken1) a1_drv(1, 0, 1, 20, 32'h0000_0BAD, 4'hF);
      else         a1_drv(0, 0, 0, 0, 32'h0, 4'h0);
      #1;
      if (!clken1) begin
        check_eq("frz_a_wait",    32'(a1.waitrequest), 32'd1);
        check_eq("frz_b_wait",    32'(b1.waitrequest), 32'd1);
        check_eq("frz_rdv_hold",  32'(b1.readdatavalid), 32'(held_v));
        check_eq("frz_data_hold", b1.readdata, held_d);
      end
      tick;
      if (clken1) begin
        if (idx < 16) idx++;
        if (b1.readdatavalid) begin
          check_eq("frz_stream", b1.readdata, pat(nrecv));
          nrecv++;
        end
      end
      held_v = b1.readdatavalid; held_d = b1.readdata;
    end
    clken1 = 1'b1;
    a1_drv(0, 0, 0, 0, 32'h0, 4'h0);
    check_eq("frz_count", 32'(nrecv), 32'd16);

    b1_drv(1, 1, 0, 20, 32'h0, 4'h0);
    tick;
    b1_drv(0, 0, 0, 0, 32'h0, 4'h0);
    tick;
    check_eq("frz_nowrite_rdv",  32'(b1.readdatavalid), 32'd1);
    check_eq("frz_nowrite_data", b1.readdata, 32'h0000_0055);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
